// File: rtl/arb4_rr_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package arb4_rr_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } arb_state_e;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arb4_rr_pick.sv
// Combinational round-robin picker: rotate the request bus so the slot after
// ptr lands at bit 0, priority-encode the lowest set bit, then unrotate.
module arb4_rr_pick
  import arb4_rr_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic [IDX_W-1:0]   base;
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   enc;

  // Search starts one past the last owner; index arithmetic wraps modulo 4.
  assign base = ptr + IDX_W'(1);

  // Rotate so rot[0] is the highest-priority requester.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[base + IDX_W'(i)];
    end
  end

  // Priority-encode: scan downwards so the lowest set bit is written last.
  always_comb begin
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
  end

  assign win_idx = base + enc;
  assign any     = |req;

endmodule

// File: rtl/arb4_rr_ctl.sv
// Four-requester round-robin arbiter with registered one-hot grant, a one-cycle
// dead gap between grants and a bounded hold counter against starvation.
// Optional feature: define ARB4_RR_LOCK_EN to add a LOCK input that suppresses
// preemption (and freezes the hold counter) while a grant is active.
// HOLD_MAX must lie in 2..255 and 2**CNT_W must exceed HOLD_MAX.
module arb4_rr_ctl
  import arb4_rr_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic [NUM_REQ-1:0] REQ,
`ifdef ARB4_RR_LOCK_EN
  input  logic               LOCK,
`endif
  output logic [NUM_REQ-1:0] GNT,
  output logic               GNT_VLD,
  output logic [IDX_W-1:0]   GNT_ID,
  output logic               IDLE
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               gnt_vld_q;
  logic [IDX_W-1:0]   gnt_id_q;

  logic [IDX_W-1:0]   win_idx;
  logic               req_any;
  logic               owner_req;
  logic               competitor;
  logic               lock_act;

`ifdef ARB4_RR_LOCK_EN
  assign lock_act = LOCK;
`else
  assign lock_act = 1'b0;
`endif

  arb4_rr_pick u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any     (req_any)
  );

  assign owner_req  = REQ[ptr_q];
  assign competitor = |(REQ & ~onehot4(ptr_q));

  // Arbitration FSM; grant outputs are registered alongside the state.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_GAP: begin
          if (req_any) begin
            state_q   <= S_GRANT;
            ptr_q     <= win_idx;
            cnt_q     <= '0;
            gnt_q     <= onehot4(win_idx);
            gnt_vld_q <= 1'b1;
            gnt_id_q  <= win_idx;
          end else begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
          end
        end
        S_GRANT: begin
          // Release wins over timeout; both end in the same gap.
          if (!owner_req || (!lock_act && (cnt_q == CNT_LAST) && competitor)) begin
            state_q   <= S_GAP;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
          end else if (!lock_act && (cnt_q != CNT_LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          gnt_q     <= '0;
          gnt_vld_q <= 1'b0;
          gnt_id_q  <= '0;
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign GNT_VLD = gnt_vld_q;
  assign GNT_ID  = gnt_id_q;
  // NOR4 idle detect, independent of reset.
  assign IDLE    = ~|REQ;

endmodule

// File: tb/tb_arb4_rr_ctl.sv
// Self-checking bench for arb4_rr_ctl: a behavioural reference model pushes the
// expected grant for each driven request word; it is popped after the edge.
module tb_arb4_rr_ctl;

  localparam int unsigned HOLD = 8;

  logic       CLK = 1'b0;
  logic       RN  = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic       lock = 1'b0;
  logic [3:0] GNT;
  logic       GNT_VLD;
  logic [1:0] GNT_ID;
  logic       IDLE;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] sb_q[$];

  // Reference model state
  int m_state;  // 0 idle, 1 grant, 2 gap
  int m_ptr;
  int m_cnt;
  int m_own;    // -1 when no grant

  arb4_rr_ctl #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .CLK     (CLK),
    .RN      (RN),
    .REQ     (REQ),
`ifdef ARB4_RR_LOCK_EN
    .LOCK    (lock),
`endif
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .GNT_ID  (GNT_ID),
    .IDLE    (IDLE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 3;
    m_cnt   = 0;
    m_own   = -1;
  endtask

  function automatic int model_search(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model by one edge that samples r.
  task automatic model_step(input logic [3:0] r);
    int w;
    if (m_state == 1) begin
      if (!r[m_ptr]) begin
        m_state = 2; m_own = -1;
      end else if (m_cnt == HOLD - 1 && (r & ~(4'b0001 << m_ptr)) != 4'b0000) begin
        m_state = 2; m_own = -1;
      end else if (m_cnt < HOLD - 1) begin
        m_cnt++;
      end
    end else begin
      w = model_search(r, m_ptr);
      if (w >= 0) begin
        m_state = 1; m_ptr = w; m_cnt = 0; m_own = w;
      end else begin
        m_state = 0; m_own = -1;
      end
    end
  endtask

  // Drive one request word for one edge and compare against the scoreboard.
  task automatic cycle(input logic [3:0] r);
    logic [5:0] exp;
    logic [5:0] got;
    REQ = r;
    #0;
    check_eq("idle_comb", IDLE, (r == 4'b0000));
    model_step(r);
    if (m_own >= 0) sb_q.push_back({4'b0001 << m_own, 2'(m_own)});
    else sb_q.push_back(6'b000000);
    @(posedge CLK);
    #1;
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      got = {GNT, GNT_ID};
      check_eq("sb_gnt", got, exp);
      check_eq("sb_vld", GNT_VLD, (exp[5:2] != 4'b0000));
    end
  endtask

  task automatic do_reset();
    REQ = 4'b0000;
    RN  = 1'b0;
    model_reset();
    #3;
    check_eq("rst_gnt", GNT, 4'b0000);
    RN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    model_reset();
    // Reset state and IDLE while RN is low.
    #3;
    check_eq("rst_gnt0", GNT, 4'b0000);
    check_eq("rst_vld0", GNT_VLD, 1'b0);
    check_eq("rst_id0", GNT_ID, 2'd0);
    check_eq("rst_idle0", IDLE, 1'b1);
    for (int i = 0; i < 4; i++) begin
      REQ = 4'b0001 << i;
      #1;
      check_eq("rst_idle_bit", IDLE, 1'b0);
    end
    REQ = 4'b0000;
    #1;
    check_eq("rst_idle1", IDLE, 1'b1);
    @(posedge CLK);
    #2;
    RN = 1'b1;
    @(posedge CLK);
    #1;

    // Basic grant, release, gap, next grant.
    cycle(4'b0110);
    check_eq("first_gnt", GNT, 4'b0010);
    check_eq("first_id", GNT_ID, 2'd1);
    cycle(4'b0110);
    check_eq("hold_gnt", GNT, 4'b0010);
    cycle(4'b0100);
    check_eq("gap_gnt", GNT, 4'b0000);
    cycle(4'b0100);
    check_eq("second_gnt", GNT, 4'b0100);
    check_eq("second_id", GNT_ID, 2'd2);
    cycle(4'b0000);
    cycle(4'b0000);

    // Full contention: 8-cycle grants, single gap, order 0,1,2,3,0.
    do_reset();
    for (int n = 0; n < 45; n++) begin
      cycle(4'b1111);
      if (n % 9 < 8) check_eq("rot_gnt", GNT, 4'b0001 << ((n / 9) % 4));
      else check_eq("rot_gap", GNT, 4'b0000);
    end
    cycle(4'b0000);

    // Lone requester holds indefinitely, then timeout preempts immediately.
    for (int n = 0; n < 40; n++) begin
      cycle(4'b0001);
      check_eq("solo_gnt", GNT, 4'b0001);
    end
    cycle(4'b0101);
    check_eq("preempt_gap", GNT, 4'b0000);
    cycle(4'b0101);
    check_eq("preempt_next", GNT, 4'b0100);

    // Asynchronous reset mid-grant with GNT=1000.
    cycle(4'b1001);
    cycle(4'b1001);
    check_eq("pre_rst_gnt", GNT, 4'b1000);
    #2;
    RN = 1'b0;
    model_reset();
    sb_q.delete();
    #1;
    check_eq("async_gnt", GNT, 4'b0000);
    check_eq("async_vld", GNT_VLD, 1'b0);
    check_eq("async_id", GNT_ID, 2'd0);
    check_eq("async_idle", IDLE, 1'b0);
    #2;
    RN = 1'b1;
    cycle(4'b1001);
    check_eq("post_rst_gnt", GNT, 4'b0001);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle(4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
